// File: rtl/tick_bcd_timer.sv
// rtl/tick_bcd_timer.sv - slow-clock tick detector driving a BCD MM:SS timer
//
// Samples a divided slow clock as data in the i_clk domain, turns each rising
// edge into a one-cycle tick and counts ticks as MM:SS while in RUN.
//
// Ports:
//   i_clk, rst            system clock, synchronous active-high reset
//   i_tick_clk            slow square wave, asynchronous to i_clk
//   i_start/i_stop/i_clear single-cycle control requests (clear > stop > start)
//   o_sec_ones..o_min_tens BCD digits of the elapsed time
//   o_running             high while counting
//   o_tick / o_wrap       one-cycle pulses on each increment / rollover to 00:00
module tick_bcd_timer #(
  parameter int MIN_LIMIT   = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       i_tick_clk,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_clear,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic       o_running,
  output logic       o_tick,
  output logic       o_wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int         MAX_MIN      = MIN_LIMIT - 1;
  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_int;

  state_t state_q, state_d;

  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       tick_q, tick_d;
  logic       wrap_q, wrap_d;

  logic count_en;
  logic min_at_max;

  // Synchronizer shifts toward the MSB; the MSB is the synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_tick_clk};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign tick_int = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Control FSM; a simultaneous start and stop resolves to stop.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else if (i_stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (i_start) begin
      state_d = ST_RUN;
    end
    running_d = (state_d == ST_RUN);
  end

  // Counting uses the state before the edge, so a tick alongside a stop is
  // still taken and a tick alongside a start is not.
  assign count_en   = tick_int && (state_q == ST_RUN) && !i_clear;
  assign min_at_max = (min_tens_q == MAX_MIN_TENS) && (min_ones_q == MAX_MIN_ONES);

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    if (i_clear) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (count_en) begin
      tick_d = 1'b1;
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_at_max) begin
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
            wrap_d     = 1'b1;
          end else if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            min_tens_d = min_tens_q + 4'd1;
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      state_q    <= ST_IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
    end
  end

  assign o_sec_ones = sec_ones_q;
  assign o_sec_tens = sec_tens_q;
  assign o_min_ones = min_ones_q;
  assign o_min_tens = min_tens_q;
  assign o_running  = running_q;
  assign o_tick     = tick_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// tb/tb_tick_bcd_timer.sv - bench for tick_bcd_timer (default and MIN_LIMIT=2 instances)
module tb_tick_bcd_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_clk = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;

  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic a_run, a_tick, a_wrap, b_run, b_tick, b_wrap;

  always #5 clk = ~clk;

  tick_bcd_timer u_dut_a (
    .i_clk(clk), .rst(rst), .i_tick_clk(tick_clk),
    .i_start(start), .i_stop(stop), .i_clear(clear),
    .o_sec_ones(a_so), .o_sec_tens(a_st), .o_min_ones(a_mo), .o_min_tens(a_mt),
    .o_running(a_run), .o_tick(a_tick), .o_wrap(a_wrap)
  );

  tick_bcd_timer #(.MIN_LIMIT(2)) u_dut_b (
    .i_clk(clk), .rst(rst), .i_tick_clk(tick_clk),
    .i_start(start), .i_stop(stop), .i_clear(clear),
    .o_sec_ones(b_so), .o_sec_tens(b_st), .o_min_ones(b_mo), .o_min_tens(b_mt),
    .o_running(b_run), .o_tick(b_tick), .o_wrap(b_wrap)
  );

  wire [15:0] time_a = {a_mt, a_mo, a_st, a_so};
  wire [15:0] time_b = {b_mt, b_mo, b_st, b_so};

  int checks = 0;
  int errors = 0;

  // Pulse counters and longest high run for {a_tick, b_tick, a_wrap, b_wrap}.
  int pulse_cnt[4];
  int run_len[4];
  int max_run[4];

  always @(negedge clk) begin
    logic [3:0] s;
    s = {b_wrap, a_wrap, b_tick, a_tick};
    for (int m = 0; m < 4; m++) begin
      if (s[m]) begin
        pulse_cnt[m]++;
        run_len[m]++;
        if (run_len[m] > max_run[m]) max_run[m] = run_len[m];
      end else begin
        run_len[m] = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One slow-clock period; lat = edges from the rise until a_tick is seen.
  task automatic slow_tick(input int hi, input int lo, output int lat);
    lat = -1;
    tick_clk = 1'b1;
    for (int k = 1; k <= hi + lo; k++) begin
      step();
      if (a_tick && lat < 0) lat = k;
      if (k == hi) tick_clk = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0]  ctrl;     // {rst, clear, stop, start}, pulsed for one cycle
    int          n_ticks;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_run;
  } row_t;

  row_t rows[12];

  task automatic apply_row(input int i);
    int lat;
    if (rows[i].ctrl != 4'b0000) begin
      {rst, clear, stop, start} = rows[i].ctrl;
      step();
      {rst, clear, stop, start} = 4'b0000;
    end
    for (int t = 0; t < rows[i].n_ticks; t++) slow_tick(4, 4, lat);
    check($sformatf("row%0d time_a", i), {16'd0, time_a}, {16'd0, rows[i].exp_a});
    check($sformatf("row%0d time_b", i), {16'd0, time_b}, {16'd0, rows[i].exp_b});
    check($sformatf("row%0d running", i), {31'd0, a_run}, {31'd0, rows[i].exp_run});
  endtask

  initial begin
    int lat;

    rows[0]  = '{4'b0000, 47, 16'h0059, 16'h0059, 1'b1};
    rows[1]  = '{4'b0000,  1, 16'h0100, 16'h0100, 1'b1};
    rows[2]  = '{4'b0000, 59, 16'h0159, 16'h0159, 1'b1};
    rows[3]  = '{4'b0000,  1, 16'h0200, 16'h0000, 1'b1};
    rows[4]  = '{4'b0010,  3, 16'h0200, 16'h0000, 1'b0};
    rows[5]  = '{4'b0011,  2, 16'h0200, 16'h0000, 1'b0};
    rows[6]  = '{4'b0001, 87, 16'h0327, 16'h0127, 1'b1};
    rows[7]  = '{4'b1000,  0, 16'h0000, 16'h0000, 1'b0};
    rows[8]  = '{4'b0001,  5, 16'h0005, 16'h0005, 1'b1};
    rows[9]  = '{4'b0011,  0, 16'h0008, 16'h0008, 1'b0};
    rows[10] = '{4'b0001, 22, 16'h0030, 16'h0030, 1'b1};
    rows[11] = '{4'b0000,  3, 16'h0000, 16'h0000, 1'b0};

    // Reset for three cycles, then slow-clock activity with no start.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset time_a", {16'd0, time_a}, 32'h0);
    check("reset time_b", {16'd0, time_b}, 32'h0);
    check("reset flags", {29'd0, a_run, a_tick, a_wrap}, 32'h0);
    for (int t = 0; t < 5; t++) slow_tick(4, 4, lat);
    check("idle time_a", {16'd0, time_a}, 32'h0);
    check("idle running", {31'd0, a_run}, 32'h0);
    check("idle pulses", pulse_cnt[0] + pulse_cnt[2], 0);

    // Start, then 12 ticks with 8/8 phases; each tick lands 3 edges after the rise.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start running", {31'd0, a_run}, 32'h1);
    for (int t = 0; t < 12; t++) begin
      slow_tick(8, 8, lat);
      check($sformatf("latency tick%0d", t), lat, 3);
    end
    check("basic time_a", {16'd0, time_a}, 32'h0012);
    check("basic time_b", {16'd0, time_b}, 32'h0012);

    // Carry, wrap on the MIN_LIMIT=2 instance, pause, start+stop, reset mid-count.
    for (int i = 0; i <= 8; i++) apply_row(i);

    // Stop in the same cycle as tick_int: tick still counted, then PAUSE.
    tick_clk = 1'b1;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop+tick time_a", {16'd0, time_a}, 32'h0006);
    check("stop+tick o_tick", {31'd0, a_tick}, 32'h1);
    check("stop+tick running", {31'd0, a_run}, 32'h0);
    repeat (5) step();
    tick_clk = 1'b0;
    repeat (6) step();
    for (int t = 0; t < 4; t++) slow_tick(4, 4, lat);
    check("paused time_a", {16'd0, time_a}, 32'h0006);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 2; t++) slow_tick(4, 4, lat);
    check("resume time_a", {16'd0, time_a}, 32'h0008);
    check("resume running", {31'd0, a_run}, 32'h1);

    apply_row(9);
    apply_row(10);

    // Clear, start and tick_int together at 00:30: clear wins, no tick.
    tick_clk = 1'b1;
    step();
    step();
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    check("clr+start time_a", {16'd0, time_a}, 32'h0);
    check("clr+start time_b", {16'd0, time_b}, 32'h0);
    check("clr+start running", {31'd0, a_run}, 32'h0);
    check("clr+start o_tick", {30'd0, b_tick, a_tick}, 32'h0);
    repeat (5) step();
    tick_clk = 1'b0;
    repeat (6) step();

    apply_row(11);

    check("total ticks a", pulse_cnt[0], 237);
    check("total ticks b", pulse_cnt[1], 237);
    check("total wraps a", pulse_cnt[2], 0);
    check("total wraps b", pulse_cnt[3], 1);
    check("tick width a", max_run[0], 1);
    check("wrap width b", max_run[3], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_bcd_timer.md
# tick_bcd_timer

Downstream consumer of the divided slow clock produced by the team's clock divider: samples that low-rate square wave in the system clock domain, converts each rising edge into a single-cycle tick, and accumulates ticks into a BCD MM:SS timer with start/stop/clear control. Its digit outputs feed the display multiplexer. All logic runs on `i_clk`; the slow clock is treated as data, never as a clock.

## Interface
Parameters:
- `MIN_LIMIT`, 60: minutes modulus; minutes count 0..MIN_LIMIT-1. Legal range 1..99.
- `SYNC_STAGES`, 2: synchronizer flops on `i_tick_clk` before edge detection. Legal range ≥2.

Ports:
- `i_clk`  in  1  system clock. One clock.
- `rst`  in  1  reset, synchronous and active-high.
- `i_tick_clk`  in  1  divided slow clock, for example the 1 Hz output. Asynchronous to `i_clk` for design purposes.
- `i_start`  in  1  single-cycle request to count.
- `i_stop`  in  1  single-cycle request to pause.
- `i_clear`  in  1  single-cycle request to zero the time and go idle.
- `o_sec_ones`  out  4  BCD seconds units, 0..9.
- `o_sec_tens`  out  4  BCD seconds tens, 0..5.
- `o_min_ones`  out  4  BCD minutes units, 0..9.
- `o_min_tens`  out  4  BCD minutes tens, 0..9.
- `o_running`  out  1  high while the state is RUN.
- `o_tick`  out  1  one-cycle pulse, aligned with each digit increment.
- `o_wrap`  out  1  one-cycle pulse, aligned with rollover to 00:00.

## Operation
- **Synchronizer.** `i_tick_clk` passes through `SYNC_STAGES` flops. One more flop holds the previous synchronized value. `tick_int` = synchronized value high AND previous value low.
- **States.**
  - IDLE: reset or after clear; not counting.
  - RUN: counting.
  - PAUSE: holding the current time.
- **Transitions.** Requests are evaluated every cycle with priority clear > stop > start.
  - `i_clear` in any state → IDLE, and all digits → 0.
  - `i_stop` in RUN → PAUSE. In IDLE or PAUSE it is ignored.
  - `i_start` in IDLE or PAUSE → RUN. In RUN it is ignored.
  - `i_start` and `i_stop` asserted together: stop wins. RUN goes to PAUSE; IDLE and PAUSE stay put.
- **Counting.** The time increments on a cycle where `tick_int` = 1, the current state is RUN, and `i_clear` = 0.
  - A tick in the same cycle as `i_stop` is still counted, because the state is RUN before the edge.
  - A tick in the same cycle as `i_start` from IDLE or PAUSE is not counted.
- **BCD increment.** Each digit increments with a ripple carry to the next:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into minutes.
  - Minutes wrap at MIN_LIMIT-1 → 0, as a two-digit BCD value.
- **Rollover.** When the time moves from (MIN_LIMIT-1):59 to 00:00, `o_wrap` pulses together with `o_tick`. Counting continues in RUN.
- **Digit invariant.** Digits never hold non-BCD codes. Seconds tens never exceeds 5. Minutes never reach MIN_LIMIT.
- **Reset.** All digits are 0. `o_running` = 0, `o_tick` = 0, `o_wrap` = 0. State is IDLE. Synchronizer and previous-value flops are 0.
  - A tick that appears because `i_tick_clk` is high at reset release is harmless, since the state is IDLE.
  - Reset asserted mid-count takes effect at the next `i_clk` edge, overriding all requests.

## Timing
- **Tick latency (SYNC_STAGES=2).** Let `i_tick_clk` rise and meet setup before edge E0.
  - sync1 goes high at E0.
  - sync2 goes high at E1.
  - `tick_int` is high in the cycle between E1 and E2.
  - Digits, `o_tick` and `o_wrap` update at E2.
  - Total: 3 `i_clk` edges. Each additional sync stage adds one edge.
- **Tick width.** Exactly one tick per rising edge of `i_tick_clk`, whatever its high time, provided its high and low phases each last at least SYNC_STAGES+1 `i_clk` cycles.
- **Control latency.** `o_running` and the digit clear reflect a request at the first `i_clk` edge after it is sampled.
- **Outputs.** All outputs are registered; no combinational path from any input to any output.
- **Pulse width.** `o_tick` and `o_wrap` are high for exactly one cycle.

## Test plan
- **Reset and idle.** Hold `rst` for 3 cycles, then toggle `i_tick_clk` 5 times without a start.
  - Required: digits stay 00:00; `o_running`, `o_tick` and `o_wrap` stay 0.
- **Basic count and latency.** Start, then drive 12 rising edges of `i_tick_clk`, each with 8-cycle high and 8-cycle low phases.
  - Required: display reads 00:12.
  - Each `o_tick` appears exactly 3 edges after its `i_tick_clk` rise.
- **Carry and wrap with MIN_LIMIT=2.**
  - Count to 00:59, then one tick. Required: 01:00.
  - Count to 01:59, then one tick. Required: 00:00 with `o_wrap`=1 for 1 cycle, and `o_running` stays 1.
- **Pause and resume.**
  - At 00:05, assert `i_stop` in the same cycle as `tick_int`. Required: 00:06, state PAUSE.
  - Apply 4 more ticks. Required: still 00:06.
  - `i_start`, then 2 ticks. Required: 00:08.
- **Simultaneous requests.**
  - `i_start` and `i_stop` together in RUN. Required: PAUSE.
  - `i_clear`, `i_start` and a tick together at 00:30. Required: 00:00, IDLE, `o_tick`=0.
- **Reset mid-count.** Assert `rst` for one cycle at 03:27 while RUN. Required: next cycle 00:00 with `o_running`=0.
